code_entry_buffer: RTL and testbench



---
 rtl/code_lock_pkg.sv | 24 ++
 rtl/tmr_inactivity.sv | 55 +++++
 rtl/code_entry_buffer.sv | 155 +++++++++++++++
 tb/tb_code_entry_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_pkg
// Purpose  : Shared digit type, digit limit and entry-state encoding for the
//            code-entry buffer and the lock FSM, so both agree on encodings.
// Contents : t_digit        - one BCD digit
//            DIGIT_MAX      - largest accepted digit value
//            t_entry_state  - S_IDLE / S_ENTRY / S_DONE
// Revision : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

    typedef logic [3:0] t_digit;

    localparam t_digit DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } t_entry_state;

endpackage : code_lock_pkg
`default_nettype wire

// File: rtl/tmr_inactivity.sv
`default_nettype none
// ============================================================================
// Module   : tmr_inactivity
// Purpose  : Inactivity timer. Counts while i_run is high and flags expiry
//            with a one-cycle pulse when the count reaches p_timeout-1.
// Ports    : i_clk     - system clock
//            i_rst     - synchronous reset, active-high
//            i_run     - advance the count this cycle
//            i_reload  - force the count back to 0 (wins over i_run)
//            o_expire  - high while the count sits at p_timeout-1
// Revision : 1.0 - initial release
// ============================================================================
module tmr_inactivity #(
    parameter int p_timeout = 250_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    input  logic i_reload,
    output logic o_expire
);

    localparam int                 p_tmr_w = $clog2(p_timeout);
    localparam logic [p_tmr_w-1:0] c_last  = p_tmr_w'(p_timeout - 1);

    logic [p_tmr_w-1:0] count_q;
    logic [p_tmr_w-1:0] count_d;

    // The count only ever leaves 0 while running, and p_timeout >= 2, so
    // expiry can never be flagged from an idle (zero) count.
    assign o_expire = (count_q == c_last);

    always_comb begin
        count_d = count_q;
        if (i_reload) begin
            count_d = '0;
        end else if (o_expire) begin
            // Wrap so the expiry is a single-cycle pulse even if the
            // owner keeps i_run asserted or stops running.
            count_d = '0;
        end else if (i_run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : tmr_inactivity
`default_nettype wire

// File: rtl/code_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : code_entry_buffer
// Purpose  : Collects digit strobes into a shift buffer (newest at index 0),
//            drives the display array, emits the packed word with a one-cycle
//            valid pulse when full and clears itself after inactivity.
// Ports    : i_clk, i_rst          - clock, synchronous active-high reset
//            i_code, i_code_vld    - digit and its one-cycle strobe
//            i_clear               - synchronous clear from the lock FSM
//            i_bksp                - backspace strobe (CODE_ENTRY_BACKSPACE_EN)
//            o_digits              - display digits, index 0 newest
//            o_cnt                 - digits currently entered
//            o_word, o_word_vld    - packed code and its fill pulse
//            o_timeout             - pulse when a partial entry is abandoned
// Options  : CODE_ENTRY_BACKSPACE_EN adds the i_bksp port and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module code_entry_buffer
    import code_lock_pkg::*;
#(
    parameter int p_digits  = 4,
    parameter int p_timeout = 250_000_000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [3:0]                   i_code,
    input  logic                         i_code_vld,
    input  logic                         i_clear,
`ifdef CODE_ENTRY_BACKSPACE_EN
    input  logic                         i_bksp,
`endif
    output logic [3:0]                   o_digits [p_digits],
    output logic [$clog2(p_digits+1)-1:0] o_cnt,
    output logic [4*p_digits-1:0]        o_word,
    output logic                         o_word_vld,
    output logic                         o_timeout
);

    localparam int               c_cnt_w = $clog2(p_digits + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_digits);

    t_entry_state         state_q, state_d;
    t_digit               buf_q [p_digits];
    t_digit               buf_d [p_digits];
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [4*p_digits-1:0] word_q, word_d;
    logic                 word_vld_q, word_vld_d;
    logic                 timeout_q, timeout_d;

    logic                 tmr_reload;
    logic                 tmr_run;
    logic                 tmr_expire;

    // Any strobe (even a rejected digit) holds the timer for that cycle;
    // accepted digits reload it explicitly.
    assign tmr_run = (state_q != S_IDLE) && !i_code_vld;

    tmr_inactivity #(
        .p_timeout (p_timeout)
    ) u_tmr (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (tmr_run),
        .i_reload (tmr_reload),
        .o_expire (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        timeout_d  = 1'b0;
        tmr_reload = 1'b0;

        if (i_clear) begin
            for (int i = 0; i < p_digits; i++) buf_d[i] = '0;
            cnt_d      = '0;
            state_d    = S_IDLE;
            tmr_reload = 1'b1;
        end else if (tmr_expire) begin
            // A completed word is dropped silently; only a partial
            // entry counts as abandoned.
            for (int i = 0; i < p_digits; i++) buf_d[i] = '0;
            cnt_d     = '0;
            state_d   = S_IDLE;
            timeout_d = (state_q == S_ENTRY);
`ifdef CODE_ENTRY_BACKSPACE_EN
        end else if (i_bksp) begin
            if (state_q == S_ENTRY) begin
                for (int i = 0; i < p_digits - 1; i++) buf_d[i] = buf_q[i+1];
                buf_d[p_digits-1] = '0;
                cnt_d      = cnt_q - 1'b1;
                tmr_reload = 1'b1;
                if (cnt_q == c_cnt_w'(1)) state_d = S_IDLE;
            end else if (state_q == S_DONE) begin
                for (int i = 0; i < p_digits; i++) buf_d[i] = '0;
                cnt_d      = '0;
                state_d    = S_IDLE;
                tmr_reload = 1'b1;
            end
`endif
        end else if (i_code_vld && (i_code <= DIGIT_MAX)) begin
            tmr_reload = 1'b1;
            if (state_q == S_DONE) begin
                // Digit after a full word starts a fresh word.
                for (int i = 1; i < p_digits; i++) buf_d[i] = '0;
                buf_d[0] = i_code;
                cnt_d    = c_cnt_w'(1);
                state_d  = S_ENTRY;
            end else begin
                for (int i = 1; i < p_digits; i++) buf_d[i] = buf_q[i-1];
                buf_d[0] = i_code;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_d == c_full) begin
                    state_d    = S_DONE;
                    word_vld_d = 1'b1;
                    for (int i = 0; i < p_digits; i++) word_d[4*i +: 4] = buf_d[i];
                end else begin
                    state_d = S_ENTRY;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < p_digits; i++) buf_q[i] <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        for (int i = 0; i < p_digits; i++) o_digits[i] = buf_q[i];
    end

    assign o_cnt      = cnt_q;
    assign o_word     = word_q;
    assign o_word_vld = word_vld_q;
    assign o_timeout  = timeout_q;

endmodule : code_entry_buffer
`default_nettype wire

// File: tb/tb_code_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_entry_buffer
// Purpose  : Directed self-checking bench for code_entry_buffer with
//            p_digits=4, p_timeout=8. Backspace cases are built only when
//            CODE_ENTRY_BACKSPACE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_entry_buffer;

    localparam int c_digits  = 4;
    localparam int c_timeout = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  code;
    logic        code_vld;
    logic        clear;
    logic        bksp;
    logic [3:0]  digits [c_digits];
    logic [2:0]  cnt;
    logic [15:0] word;
    logic        word_vld;
    logic        timeout;

    int n_total = 0;
    int n_bad   = 0;

    code_entry_buffer #(
        .p_digits  (c_digits),
        .p_timeout (c_timeout)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_code     (code),
        .i_code_vld (code_vld),
        .i_clear    (clear),
`ifdef CODE_ENTRY_BACKSPACE_EN
        .i_bksp     (bksp),
`endif
        .o_digits   (digits),
        .o_cnt      (cnt),
        .o_word     (word),
        .o_word_vld (word_vld),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        logic [15:0] v;
        for (int i = 0; i < c_digits; i++) v[4*i +: 4] = digits[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d);
        code     = d;
        code_vld = 1'b1;
        tick();
        code_vld = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic seen;

    initial begin
        rst = 1'b1; code = '0; code_vld = 1'b0; clear = 1'b0; bksp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_cnt",  cnt,      0);
        chk("rst_disp", disp(),   0);
        chk("rst_word", word,     0);
        chk("rst_vld",  word_vld, 0);
        chk("rst_to",   timeout,  0);

        // 1,2,3,4 on separated cycles
        strobe(4'd1); tick();
        strobe(4'd2); tick();
        strobe(4'd3);
        chk("fill3_vld", word_vld, 0);
        tick();
        strobe(4'd4);
        chk("fill_vld",  word_vld, 1);
        chk("fill_word", word,     16'h1234);
        chk("fill_disp", disp(),   16'h1234);
        chk("fill_cnt",  cnt,      4);
        // Full word left alone: silent clear on the 8th idle cycle
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                chk("fill_vld_1cyc", word_vld, 0);
                chk("fill_word_hold", word,    16'h1234);
            end
            if (k == 7) chk("done_cnt_k7", cnt, 4);
            seen = seen | timeout;
        end
        chk("done_clr_cnt",  cnt,    0);
        chk("done_clr_disp", disp(), 0);
        chk("done_no_to",    seen,   0);

        // Partial entry 5,7 then timeout
        strobe(4'd5);
        strobe(4'd7);
        chk("part_disp", disp(), 16'h0057);
        seen = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            seen = seen | timeout | word_vld;
        end
        chk("part_no_early", seen, 0);
        chk("part_cnt_k7",   cnt,  2);
        tick();
        chk("part_to",       timeout, 1);
        chk("part_to_cnt",   cnt,     0);
        chk("part_to_disp",  disp(),  0);
        chk("part_to_vld",   word_vld, 0);
        tick();
        chk("part_to_1cyc",  timeout, 0);

        // Digit filter
        strobe(4'hC);
        chk("filt_cnt", cnt, 0);
        strobe(4'h9);
        chk("filt9_cnt",  cnt,    1);
        chk("filt9_disp", disp(), 16'h0009);
        do_clear();
        chk("clr_cnt", cnt, 0);

        // Clear wins over a same-cycle digit
        strobe(4'd1); strobe(4'd2); strobe(4'd3);
        code = 4'd6; code_vld = 1'b1; clear = 1'b1;
        tick();
        code_vld = 1'b0; clear = 1'b0;
        chk("clrd_cnt",  cnt,      0);
        chk("clrd_disp", disp(),   0);
        chk("clrd_vld",  word_vld, 0);
        chk("clrd_to",   timeout,  0);

        // Back-to-back fill, fifth digit starts a fresh word
        strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
        chk("b2b_vld",  word_vld, 1);
        chk("b2b_word", word,     16'h1234);
        strobe(4'd8);
        chk("fresh_disp", disp(),   16'h0008);
        chk("fresh_cnt",  cnt,      1);
        chk("fresh_vld",  word_vld, 0);
        chk("fresh_word", word,     16'h1234);
        // Still in S_ENTRY: a 2nd digit extends the fresh word
        strobe(4'd2);
        chk("fresh2_disp", disp(), 16'h0082);
        chk("fresh2_cnt",  cnt,    2);

        // Reset mid-entry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_cnt",  cnt,     0);
        chk("rstmid_disp", disp(),  0);
        chk("rstmid_word", word,    0);
        chk("rstmid_to",   timeout, 0);

`ifdef CODE_ENTRY_BACKSPACE_EN
        strobe(4'd3); strobe(4'd1);
        bksp = 1'b1; tick(); bksp = 1'b0;
        chk("bk1_cnt",  cnt,    1);
        chk("bk1_disp", disp(), 16'h0003);
        bksp = 1'b1; tick(); bksp = 1'b0;
        chk("bk2_cnt",  cnt,    0);
        chk("bk2_disp", disp(), 0);
        bksp = 1'b1; tick(); bksp = 1'b0;
        chk("bk3_cnt",  cnt,    0);
        // Backspace beats a same-cycle digit
        strobe(4'd5);
        code = 4'd6; code_vld = 1'b1; bksp = 1'b1;
        tick();
        code_vld = 1'b0; bksp = 1'b0;
        chk("bkd_cnt",  cnt,    0);
        chk("bkd_disp", disp(), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_code_entry_buffer
`default_nettype wire
